// File: rtl/sram_uart_arbiter.sv
// N-master arbiter and strobe sequencer for one 32-bit SRAM bank whose low data byte is shared with the CPLD UART.
// Build option: define ARB_RR_EN for round-robin arbitration; without it the lowest-index master always wins.
module sram_uart_arbiter #(
  parameter int          N_MASTERS      = 2,
  parameter int          RD_WAIT        = 1,
  parameter int          WR_WAIT        = 1,
  parameter int          UART_WAIT      = 2,
  parameter logic [31:0] UART_DATA_ADDR = 32'hBFD003F8,
  parameter logic [31:0] UART_STAT_ADDR = 32'hBFD003FC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_MASTERS-1:0]   m_ce,
  input  logic [N_MASTERS-1:0]   m_we,
  input  logic [32*N_MASTERS-1:0] m_addr,
  input  logic [32*N_MASTERS-1:0] m_wdata,
  input  logic [4*N_MASTERS-1:0] m_sel,
  output logic [31:0]            m_rdata,
  output logic [N_MASTERS-1:0]   m_ready,
  inout  wire  [31:0]            ram_data,
  output logic [19:0]            ram_addr,
  output logic [3:0]             ram_be_n,
  output logic                   ram_ce_n,
  output logic                   ram_oe_n,
  output logic                   ram_we_n,
  output logic                   uart_rdn,
  output logic                   uart_wrn,
  input  logic                   uart_dataready,
  input  logic                   uart_tbre,
  input  logic                   uart_tsre
);

  localparam int         IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [3:0] RD_LAST   = 4'(RD_WAIT);
  localparam logic [3:0] WR_LAST   = 4'(WR_WAIT - 1);
  localparam logic [3:0] UART_LAST = 4'(UART_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, RAM_RD, WR_SETUP, WR_PULSE, WR_HOLD, UART_RD, UART_WR, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0] grant, pick;
  logic             pick_vld, pick_we;
  logic [31:0]      pick_addr, pick_wdata;
  logic [3:0]       pick_sel;
  logic             is_stat, is_udata;
  logic [19:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       sel_q;
  logic [1:0]       dr_sync, tbre_sync, tsre_sync;
  logic [31:0]      stat_word;
  logic             ram_phase, drive_hi, drive_lo;
  int               idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dr_sync   <= '0;
      tbre_sync <= '0;
      tsre_sync <= '0;
    end else begin
      dr_sync   <= {dr_sync[0], uart_dataready};
      tbre_sync <= {tbre_sync[0], uart_tbre};
      tsre_sync <= {tsre_sync[0], uart_tsre};
    end
  end

  assign stat_word = {30'b0, dr_sync[1], tbre_sync[1] & tsre_sync[1]};

  // Round-robin searches from the master after the last grant; fixed priority always searches from 0.
  always_comb begin
    pick       = '0;
    pick_vld   = 1'b0;
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    pick_sel   = '0;
    idx        = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
`ifdef ARB_RR_EN
      idx = (int'(grant) + 1 + k) % N_MASTERS;
`else
      idx = k;
`endif
      if (!pick_vld && |(m_ce & (N_MASTERS'(1) << idx))) begin
        pick_vld   = 1'b1;
        pick       = IDX_W'(idx);
        pick_we    = |(m_we & (N_MASTERS'(1) << idx));
        pick_addr  = 32'(m_addr >> (32 * idx));
        pick_wdata = 32'(m_wdata >> (32 * idx));
        pick_sel   = 4'(m_sel >> (4 * idx));
      end
    end
  end

  assign is_stat  = (pick_addr == UART_STAT_ADDR);
  assign is_udata = (pick_addr == UART_DATA_ADDR);

  always_ff @(posedge clk) begin
    if (state == IDLE && pick_vld) begin
      wdata_q <= pick_wdata;
      sel_q   <= pick_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      grant   <= IDX_W'(N_MASTERS - 1);
      m_rdata <= '0;
    end else begin
      if (state == IDLE && pick_vld) begin
        addr_q <= pick_addr[21:2];
        grant  <= pick;
        if (is_stat) m_rdata <= stat_word;
      end
      if (state == RAM_RD && cnt == RD_LAST) m_rdata <= ram_data;
      if (state == UART_RD && cnt == UART_LAST) m_rdata <= {24'b0, ram_data[7:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt_nxt defaults to zero so every wait state is entered with a fresh count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          if (is_stat)       state_nxt = DONE;
          else if (is_udata) state_nxt = pick_we ? UART_WR : UART_RD;
          else               state_nxt = pick_we ? WR_SETUP : RAM_RD;
        end
      end
      RAM_RD:   if (cnt == RD_LAST) state_nxt = DONE;    else cnt_nxt = cnt + 4'd1;
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: if (cnt == WR_LAST) state_nxt = WR_HOLD; else cnt_nxt = cnt + 4'd1;
      WR_HOLD:  state_nxt = DONE;
      UART_RD, UART_WR: if (cnt == UART_LAST) state_nxt = DONE; else cnt_nxt = cnt + 4'd1;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    ram_phase = (state == RAM_RD) || (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
    drive_hi  = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
    drive_lo  = drive_hi || (state == UART_WR);
    ram_ce_n  = !ram_phase;
    ram_oe_n  = (state != RAM_RD);
    ram_we_n  = (state != WR_PULSE);
    ram_be_n  = ram_phase ? ~sel_q : 4'hF;
    uart_rdn  = (state != UART_RD);
    uart_wrn  = (state != UART_WR);
    m_ready   = (state == DONE) ? (N_MASTERS'(1) << grant) : '0;
  end

  assign ram_addr = addr_q;

  // The UART only listens on the low byte, so a UART write leaves the upper lanes floating.
  assign ram_data[31:8] = drive_hi ? wdata_q[31:8] : 24'bz;
  assign ram_data[7:0]  = drive_lo ? wdata_q[7:0]  : 8'bz;

endmodule
